// File: rtl/pipelined_shifter.sv
// Pipelined XLEN-bit funnel shifter with valid/ready handshake, tag passthrough and flush.
// Define SHIFTER_ROTATE_EN to enable ROL/ROR (ops 100/101); otherwise those ops pass in_a through.
module pipelined_shifter #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_a,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [2:0]              in_op,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_y,
  output logic [TAG_W-1:0]        out_tag
);
  localparam int L  = $clog2(XLEN);
  localparam int G  = (L + STAGES - 1) / STAGES;
  localparam int FW = 2 * XLEN;

  logic [FW-1:0] w_f0;
  logic [L-1:0]  w_amt0;
  logic          w_adv;
  logic          w_accept;

  // The op is fully resolved here into funnel contents plus a right-shift amount.
  // Left ops pre-shift the funnel right by one so that ~shamt gives a total of XLEN-shamt.
  always_comb begin
    w_f0   = {{XLEN{1'b0}}, in_a};
    w_amt0 = '0;
    case (in_op)
      3'b000: begin
        w_f0   = {1'b0, in_a, {(XLEN-1){1'b0}}};
        w_amt0 = ~in_shamt;
      end
      3'b001: w_amt0 = in_shamt;
      3'b011: begin
        w_f0   = {{XLEN{in_a[XLEN-1]}}, in_a};
        w_amt0 = in_shamt;
      end
`ifdef SHIFTER_ROTATE_EN
      3'b100: begin
        w_f0   = {1'b0, in_a, in_a[XLEN-1:1]};
        w_amt0 = ~in_shamt;
      end
      3'b101: begin
        w_f0   = {in_a, in_a};
        w_amt0 = in_shamt;
      end
`endif
      default: w_amt0 = '0;
    endcase
  end

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv & ~flush;
  assign w_accept = in_valid & in_ready;

  for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
    logic [FW-1:0]    w_chain [G+1];
    logic [L-1:0]     w_amt_in;
    logic             w_valid_in;
    logic [TAG_W-1:0] w_tag_in;
    logic             w_unused_amt;
    logic [FW-1:0]    r_data;
    logic [L-1:0]     r_amt;
    logic [TAG_W-1:0] r_tag;
    logic             r_valid;

    if (gs == 0) begin : g_first
      assign w_chain[0] = w_f0;
      assign w_amt_in   = w_amt0;
      assign w_valid_in = w_accept;
      assign w_tag_in   = in_tag;
    end else begin : g_next
      assign w_chain[0] = g_stage[gs-1].r_data;
      assign w_amt_in   = g_stage[gs-1].r_amt;
      assign w_valid_in = g_stage[gs-1].r_valid;
      assign w_tag_in   = g_stage[gs-1].r_tag;
    end

    // Global level index J runs MSB-first; trailing slots past the last level are wires.
    for (genvar gk = 0; gk < G; gk++) begin : g_level
      localparam int J = gs * G + gk;
      if (J < L) begin : g_mux
        localparam int B = L - 1 - J;
        assign w_chain[gk+1] = w_amt_in[B] ? (w_chain[gk] >> (2**B)) : w_chain[gk];
      end else begin : g_thru
        assign w_chain[gk+1] = w_chain[gk];
      end
    end

    assign w_unused_amt = ^w_amt_in;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_amt   <= '0;
        r_tag   <= '0;
      end else begin
        if (flush) begin
          r_valid <= 1'b0;
        end else if (w_adv) begin
          r_valid <= w_valid_in;
        end
        if (w_adv) begin
          r_data <= w_chain[G];
          r_amt  <= w_amt_in;
          r_tag  <= w_tag_in;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign out_y     = g_stage[STAGES-1].r_data[XLEN-1:0];
  assign out_tag   = g_stage[STAGES-1].r_tag;

  logic w_unused;
  assign w_unused = ^{g_stage[STAGES-1].r_data[FW-1:XLEN], g_stage[STAGES-1].r_amt};
endmodule
